// File: rtl/register_file.sv
// register_file: 2**N_B x B register file with two registered read ports, write-first bypass
// and a per-register pending scoreboard that stalls reads until the register is rewritten.
module register_file #(
    parameter int B        = 8,
    parameter int N_B      = 4,
    parameter int ZERO_REG = 0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [B-1:0]   z_in,
    input  logic           z_enb,
    input  logic [N_B-1:0] z_sel,
    input  logic           x_enb,
    input  logic [N_B-1:0] x_sel,
    input  logic           y_enb,
    input  logic [N_B-1:0] y_sel,
    input  logic           lock_enb,
    input  logic [N_B-1:0] lock_sel,
    output logic [B-1:0]   x_out,
    output logic [B-1:0]   y_out,
    output logic           x_stall,
    output logic           y_stall
);
    localparam int N = 2**N_B;

    logic [B-1:0] r [N];
    logic [N-1:0] pend;
    logic         z_ok, lock_ok;
    logic [B-1:0] x_rd, y_rd;

    // With ZERO_REG, index 0 never takes data or a lock, so it reads 0 and never stalls.
    always_comb begin
        z_ok    = z_enb && !(ZERO_REG != 0 && z_sel == '0);
        lock_ok = lock_enb && !(ZERO_REG != 0 && lock_sel == '0);
        x_stall = x_enb && pend[x_sel] && !(z_enb && z_sel == x_sel);
        y_stall = y_enb && pend[y_sel] && !(z_enb && z_sel == y_sel);
        x_rd    = (z_ok && z_sel == x_sel) ? z_in : r[x_sel];
        y_rd    = (z_ok && z_sel == y_sel) ? z_in : r[y_sel];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) r[i] <= '0;
            pend  <= '0;
            x_out <= '0;
            y_out <= '0;
        end else begin
            if (z_ok) begin
                r[z_sel]    <= z_in;
                pend[z_sel] <= 1'b0;
            end
            if (lock_ok) pend[lock_sel] <= 1'b1;
            if (x_enb && !x_stall) x_out <= x_rd;
            if (y_enb && !y_stall) y_out <= y_rd;
        end
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vector table, random traffic against a behavioural model,
// and hand-written ZERO_REG and mid-cycle reset sequences.
module tb_register_file;
    typedef struct {
        logic       ze; logic [3:0] zs; logic [7:0] zi;
        logic       le; logic [3:0] ls;
        logic       xe; logic [3:0] xs;
        logic       ye; logic [3:0] ys;
    } in_t;
    typedef struct {
        in_t        i;
        logic       exs, eys;
        logic [7:0] ex, ey;
    } vec_t;

    logic       clock = 0, reset = 0;
    logic [7:0] z_in = 0;
    logic       z_enb = 0, x_enb = 0, y_enb = 0, lock_enb = 0;
    logic [3:0] z_sel = 0, x_sel = 0, y_sel = 0, lock_sel = 0;
    logic [7:0] x_out0, y_out0, x_out1, y_out1;
    logic       x_stall0, y_stall0, x_stall1, y_stall1;

    int tests = 0, fails = 0;

    logic [7:0] mem [2][16];
    logic       pnd [2][16];
    logic [7:0] xo [2], yo [2];

    always #5 clock = ~clock;

    register_file dut (
        .clock(clock), .reset(reset), .z_in(z_in), .z_enb(z_enb), .z_sel(z_sel),
        .x_enb(x_enb), .x_sel(x_sel), .y_enb(y_enb), .y_sel(y_sel),
        .lock_enb(lock_enb), .lock_sel(lock_sel),
        .x_out(x_out0), .y_out(y_out0), .x_stall(x_stall0), .y_stall(y_stall0)
    );
    register_file #(.ZERO_REG(1)) dut_z (
        .clock(clock), .reset(reset), .z_in(z_in), .z_enb(z_enb), .z_sel(z_sel),
        .x_enb(x_enb), .x_sel(x_sel), .y_enb(y_enb), .y_sel(y_sel),
        .lock_enb(lock_enb), .lock_sel(lock_sel),
        .x_out(x_out1), .y_out(y_out1), .x_stall(x_stall1), .y_stall(y_stall1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 16; j++) begin
                mem[k][j] = 0;
                pnd[k][j] = 0;
            end
            xo[k] = 0;
            yo[k] = 0;
        end
    endtask

    function automatic logic m_stall(int k, logic en, logic [3:0] sel);
        return en && pnd[k][sel] && !(z_enb && z_sel == sel);
    endfunction

    // Instance k=1 treats register 0 as hardwired zero.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic zok, lok;
            zok = z_enb && !(k == 1 && z_sel == 0);
            lok = lock_enb && !(k == 1 && lock_sel == 0);
            if (x_enb && !m_stall(k, x_enb, x_sel)) xo[k] = (zok && z_sel == x_sel) ? z_in : mem[k][x_sel];
            if (y_enb && !m_stall(k, y_enb, y_sel)) yo[k] = (zok && z_sel == y_sel) ? z_in : mem[k][y_sel];
            if (zok) begin
                mem[k][z_sel] = z_in;
                pnd[k][z_sel] = 0;
            end
            if (lok) pnd[k][lock_sel] = 1;
        end
    endtask

    task automatic drive(input in_t v);
        z_enb = v.ze; z_sel = v.zs; z_in = v.zi;
        lock_enb = v.le; lock_sel = v.ls;
        x_enb = v.xe; x_sel = v.xs;
        y_enb = v.ye; y_sel = v.ys;
    endtask

    task automatic apply(input in_t v);
        drive(v);
        @(negedge clock);
        chk("x_stall0", 32'(x_stall0), 32'(m_stall(0, x_enb, x_sel)));
        chk("y_stall0", 32'(y_stall0), 32'(m_stall(0, y_enb, y_sel)));
        chk("x_stall1", 32'(x_stall1), 32'(m_stall(1, x_enb, x_sel)));
        chk("y_stall1", 32'(y_stall1), 32'(m_stall(1, y_enb, y_sel)));
        model_edge();
        @(posedge clock);
        #1;
        chk("x_out0", 32'(x_out0), 32'(xo[0]));
        chk("y_out0", 32'(y_out0), 32'(yo[0]));
        chk("x_out1", 32'(x_out1), 32'(xo[1]));
        chk("y_out1", 32'(y_out1), 32'(yo[1]));
    endtask

    function automatic in_t mk(logic ze, logic [3:0] zs, logic [7:0] zi, logic le, logic [3:0] ls,
                               logic xe, logic [3:0] xs, logic ye, logic [3:0] ys);
        in_t v;
        v.ze = ze; v.zs = zs; v.zi = zi; v.le = le; v.ls = ls;
        v.xe = xe; v.xs = xs; v.ye = ye; v.ys = ys;
        return v;
    endfunction

    vec_t vt [12];
    in_t  idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        //            ze zs  zi    le ls  xe xs  ye ys           exs eys  ex     ey
        vt[0]  = '{mk(1, 5, 8'hA5, 0, 0, 0, 0, 0, 0), 0, 0, 8'h00, 8'h00};
        vt[1]  = '{mk(0, 0, 8'h00, 0, 0, 1, 5, 0, 0), 0, 0, 8'hA5, 8'h00};
        vt[2]  = '{mk(1, 3, 8'h3C, 0, 0, 1, 3, 1, 3), 0, 0, 8'h3C, 8'h3C};
        vt[3]  = '{mk(0, 0, 8'h00, 1, 7, 0, 0, 0, 0), 0, 0, 8'h3C, 8'h3C};
        vt[4]  = '{mk(0, 0, 8'h00, 0, 0, 1, 7, 0, 0), 1, 0, 8'h3C, 8'h3C};
        vt[5]  = '{mk(1, 7, 8'h11, 0, 0, 1, 7, 0, 0), 0, 0, 8'h11, 8'h3C};
        vt[6]  = '{mk(1, 2, 8'h22, 1, 2, 0, 0, 0, 0), 0, 0, 8'h11, 8'h3C};
        vt[7]  = '{mk(0, 0, 8'h00, 0, 0, 1, 2, 1, 5), 1, 0, 8'h11, 8'hA5};
        vt[8]  = '{mk(1, 2, 8'h99, 0, 0, 1, 2, 0, 0), 0, 0, 8'h99, 8'hA5};
        vt[9]  = '{mk(0, 0, 8'h00, 1, 6, 0, 0, 0, 0), 0, 0, 8'h99, 8'hA5};
        vt[10] = '{mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 6), 0, 1, 8'h99, 8'hA5};
        vt[11] = '{mk(0, 0, 8'h00, 0, 0, 1, 5, 1, 5), 0, 0, 8'hA5, 8'hA5};

        model_reset();
        #2;
        chk("rst x_out", 32'(x_out0), 0);
        chk("rst y_out", 32'(y_out0), 0);
        chk("rst x_stall", 32'(x_stall0), 0);
        chk("rst y_stall", 32'(y_stall0), 0);
        @(negedge clock);
        reset = 1;
        @(posedge clock);
        #1;

        for (int n = 0; n < 12; n++) begin
            drive(vt[n].i);
            @(negedge clock);
            chk($sformatf("vec%0d x_stall", n), 32'(x_stall0), 32'(vt[n].exs));
            chk($sformatf("vec%0d y_stall", n), 32'(y_stall0), 32'(vt[n].eys));
            model_edge();
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d x_out", n), 32'(x_out0), 32'(vt[n].ex));
            chk($sformatf("vec%0d y_out", n), 32'(y_out0), 32'(vt[n].ey));
        end

        // ZERO_REG: write and lock r0 together, then read it back.
        apply(mk(1, 0, 8'hFF, 1, 0, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
        @(negedge clock);
        chk("zr x_stall", 32'(x_stall1), 0);
        chk("zr0 x_stall", 32'(x_stall0), 1);
        model_edge();
        @(posedge clock);
        #1;
        chk("zr x_out", 32'(x_out1), 0);
        chk("zr y_out", 32'(y_out1), 0);

        for (int n = 0; n < 400; n++)
            apply(mk($urandom_range(0, 1), 4'($urandom_range(0, 7)), 8'($urandom),
                     $urandom_range(0, 3) == 0, 4'($urandom_range(0, 7)),
                     $urandom_range(0, 2) != 0, 4'($urandom_range(0, 7)),
                     $urandom_range(0, 2) != 0, 4'($urandom_range(0, 7))));

        // Mid-cycle reset discards state and an in-flight write.
        apply(mk(1, 1, 8'h55, 1, 4, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 1, 1, 1, 4));
        chk("pre-rst x_out", 32'(x_out0), 8'h55);
        #2;
        reset = 0;
        drive(mk(1, 1, 8'h77, 1, 9, 1, 1, 1, 1));
        #1;
        model_reset();
        chk("mid-rst x_out", 32'(x_out0), 0);
        chk("mid-rst y_out", 32'(y_out0), 0);
        chk("mid-rst x_stall", 32'(x_stall0), 0);
        chk("mid-rst y_stall", 32'(y_stall0), 0);
        @(posedge clock);
        #3;
        reset = 1;
        drive(idle);
        @(posedge clock);
        #1;
        apply(mk(0, 0, 0, 0, 0, 1, 1, 1, 4));
        chk("post-rst r1", 32'(x_out0), 0);
        chk("post-rst y_out", 32'(y_out0), 0);
        apply(mk(0, 0, 0, 0, 0, 1, 9, 1, 4));
        chk("post-rst r9", 32'(x_out0), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
